// File: rtl/systolic_dot_engine.sv
`default_nettype none
// systolic_dot_engine: N x N weight-stationary dot-product engine with a start/busy/done FSM
// that streams OUT_NUM activation windows column by column. Rev 1.0.
module systolic_dot_engine #(
  parameter int DATA_W  = 8,
  parameter int N       = 3,
  parameter int OUT_NUM = 4,
  parameter int ACC_W   = 8,
  localparam int AW = $clog2(N*N),
  localparam int IW = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     w_we,
  input  logic [AW-1:0]            w_addr,
  input  logic [DATA_W-1:0]        w_data,
  input  logic                     act_valid,
  output logic                     act_ready,
  input  logic [N*DATA_W-1:0]      act_in,
  output logic [OUT_NUM*ACC_W-1:0] res_flat,
  output logic                     res_valid,
  output logic [IW-1:0]            res_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int BW = $clog2(N);
  localparam int PW = 2*DATA_W + ACC_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q;
  logic [BW-1:0]     beat_q;
  logic [IW-1:0]     win_q;
  logic              act_ready_q;
  logic              busy_q;
  logic              done_q;

  logic [DATA_W-1:0] w_q [N][N];

  logic [ACC_W-1:0]  prod_d [N];
  logic [ACC_W-1:0]  p_q [N];
  logic              s1_v_q;
  logic              s1_first_q;
  logic              s1_last_q;
  logic [IW-1:0]     s1_idx_q;

  logic [ACC_W-1:0]  colsum_d;
  logic [ACC_W-1:0]  acc_d;
  logic [ACC_W-1:0]  acc_q;

  logic              dl_v_q   [N];
  logic [IW-1:0]     dl_idx_q [N];
  logic [ACC_W-1:0]  dl_sum_q [N];

  logic              res_valid_q;
  logic [IW-1:0]     res_idx_q;
  logic [ACC_W-1:0]  res_q [OUT_NUM];

  logic              accept;
  logic              beat_last;
  logic              win_last;

  assign accept    = act_valid & act_ready_q;
  assign beat_last = (beat_q == BW'(N-1));
  assign win_last  = (win_q == IW'(OUT_NUM-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      win_q       <= '0;
      act_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_STREAM;
            beat_q      <= '0;
            win_q       <= '0;
            act_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_STREAM: begin
          if (accept) begin
            if (beat_last) begin
              beat_q <= '0;
              if (win_last) begin
                state_q     <= S_DRAIN;
                act_ready_q <= 1'b0;
              end else begin
                win_q <= win_q + 1'b1;
              end
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // The last window's result register was written on the previous edge.
          if (res_valid_q && (res_idx_q == IW'(OUT_NUM-1))) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          w_q[r][c] <= '0;
    end else if ((state_q == S_IDLE) && w_we) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          if (w_addr == AW'(r*N + c))
            w_q[r][c] <= w_data;
    end
  end

  always_comb begin
    for (int r = 0; r < N; r++)
      prod_d[r] = ACC_W'(PW'(act_in[r*DATA_W +: DATA_W]) * PW'(w_q[r][beat_q]));
  end

  always_comb begin
    colsum_d = '0;
    for (int r = 0; r < N; r++)
      colsum_d = colsum_d + p_q[r];
    acc_d = s1_first_q ? colsum_d : (acc_q + colsum_d);
  end

  // Fixed-length delay line: a window's total leaves it N+1 edges after its last beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++)
        p_q[r] <= '0;
      s1_v_q      <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_idx_q    <= '0;
      acc_q       <= '0;
      for (int j = 0; j < N; j++) begin
        dl_v_q[j]   <= 1'b0;
        dl_idx_q[j] <= '0;
        dl_sum_q[j] <= '0;
      end
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      for (int k = 0; k < OUT_NUM; k++)
        res_q[k] <= '0;
    end else begin
      s1_v_q <= accept;
      if (accept) begin
        for (int r = 0; r < N; r++)
          p_q[r] <= prod_d[r];
        s1_first_q <= (beat_q == '0);
        s1_last_q  <= beat_last;
        s1_idx_q   <= win_q;
      end
      if (s1_v_q)
        acc_q <= acc_d;

      dl_v_q[0]   <= s1_v_q & s1_last_q;
      dl_idx_q[0] <= s1_idx_q;
      dl_sum_q[0] <= acc_d;
      for (int j = 1; j < N; j++) begin
        dl_v_q[j]   <= dl_v_q[j-1];
        dl_idx_q[j] <= dl_idx_q[j-1];
        dl_sum_q[j] <= dl_sum_q[j-1];
      end

      res_valid_q <= dl_v_q[N-1];
      res_idx_q   <= dl_idx_q[N-1];
      if (dl_v_q[N-1])
        res_q[dl_idx_q[N-1]] <= dl_sum_q[N-1];
    end
  end

  always_comb begin
    res_flat = '0;
    for (int k = 0; k < OUT_NUM; k++)
      res_flat[k*ACC_W +: ACC_W] = res_q[k];
  end

  assign act_ready = act_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_dot_engine.sv
`default_nettype none
// Bench for systolic_dot_engine: directed and random runs scored against a plain dot-product model.
module tb_systolic_dot_engine;
  localparam int DATA_W  = 8;
  localparam int N       = 3;
  localparam int OUT_NUM = 4;
  localparam int ACC_W   = 8;
  localparam int AW      = $clog2(N*N);
  localparam int IW      = $clog2(OUT_NUM);
  localparam int QD      = 64;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     start = 1'b0;
  logic                     w_we = 1'b0;
  logic [AW-1:0]            w_addr = '0;
  logic [DATA_W-1:0]        w_data = '0;
  logic                     act_valid = 1'b0;
  logic                     act_ready;
  logic [N*DATA_W-1:0]      act_in = '0;
  logic [OUT_NUM*ACC_W-1:0] res_flat;
  logic                     res_valid;
  logic [IW-1:0]            res_idx;
  logic                     busy;
  logic                     done;

  always #5 clk = ~clk;

  systolic_dot_engine #(
    .DATA_W(DATA_W), .N(N), .OUT_NUM(OUT_NUM), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_in(act_in),
    .res_flat(res_flat), .res_valid(res_valid), .res_idx(res_idx), .busy(busy), .done(done)
  );

  int wm [N*N];
  int xs [OUT_NUM][N][N];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
    end
  endtask

  // Window capture: each completed window's expected result is pushed into the FIFO
  int cyc = 0;
  int cur [N][N];
  int beat_cnt = 0;
  int win_cnt = 0;
  int s_acc;
  int exp_val [QD];
  int exp_idx [QD];
  int exp_cyc [QD];
  int wp = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      beat_cnt = 0;
      win_cnt  = 0;
    end else if (act_valid && act_ready) begin
      for (int r = 0; r < N; r++)
        cur[r][beat_cnt] = int'(act_in[r*DATA_W +: DATA_W]);
      beat_cnt = beat_cnt + 1;
      if (beat_cnt == N) begin
        s_acc = 0;
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            s_acc = s_acc + cur[r][c] * wm[r*N + c];
        exp_val[wp % QD] = s_acc % (1 << ACC_W);
        exp_idx[wp % QD] = win_cnt;
        exp_cyc[wp % QD] = cyc;
        wp = wp + 1;
        beat_cnt = 0;
        win_cnt  = (win_cnt + 1) % OUT_NUM;
      end
    end
  end

  int rp = 0;
  int done_cnt = 0;
  int last_res_cyc = -100;
  int e;

  always @(negedge clk) begin
    if (!rst) begin
      rp = wp;
    end else begin
      if (res_valid) begin
        if (rp == wp) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_res_valid idx=%0d expected=none", res_idx);
        end else begin
          e = exp_idx[rp % QD];
          chk("res_idx", 64'(res_idx), 64'(e));
          chk("res_value", 64'(res_flat[e*ACC_W +: ACC_W]), 64'(exp_val[rp % QD]));
          chk("res_latency", 64'(cyc - exp_cyc[rp % QD]), 64'(N + 1));
          if (e == OUT_NUM - 1)
            last_res_cyc = cyc;
          rp = rp + 1;
        end
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        chk("done_after_last_res", 64'(cyc - last_res_cyc), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic write_w(input int a, input int d);
    @(negedge clk);
    w_we   = 1'b1;
    w_addr = AW'(a);
    w_data = DATA_W'(d);
    if (a < N*N)
      wm[a] = d;
    @(negedge clk);
    w_we = 1'b0;
  endtask

  // kind 0: all v, 1: index+1, 2: random, 3: only W[4]=255
  task automatic set_w(input int kind, input int v);
    for (int i = 0; i < N*N; i++) begin
      case (kind)
        0:       write_w(i, v);
        1:       write_w(i, i + 1);
        2:       write_w(i, int'($urandom_range(0, 255)));
        default: write_w(i, (i == 4) ? 255 : 0);
      endcase
    end
  endtask

  // kind 0: all v, 1: window k holds k+1, 2: random
  task automatic set_x(input int kind, input int v);
    for (int k = 0; k < OUT_NUM; k++)
      for (int r = 0; r < N; r++)
        for (int t = 0; t < N; t++)
          xs[k][r][t] = (kind == 0) ? v : (kind == 1) ? k + 1 : int'($urandom_range(0, 255));
  endtask

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random bubbles
  task automatic stream(input int mode, input bit illegal, input int max_beats);
    int  beats;
    int  guard;
    bit  sent;
    bit  v;
    bit  tog;
    beats = 0;
    tog   = 1'b1;
    for (int k = 0; k < OUT_NUM; k++) begin
      for (int t = 0; t < N; t++) begin
        if (beats < max_beats) begin
          sent  = 1'b0;
          guard = 0;
          while (!sent && guard < 50) begin
            @(negedge clk);
            guard++;
            v   = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 2) != 0);
            tog = ~tog;
            act_valid = v;
            for (int r = 0; r < N; r++)
              act_in[r*DATA_W +: DATA_W] = DATA_W'(xs[k][r][t]);
            if (illegal) begin
              start  = 1'($urandom_range(0, 1));
              w_we   = 1'($urandom_range(0, 1));
              w_addr = AW'($urandom_range(0, N*N - 1));
              w_data = DATA_W'($urandom_range(0, 255));
            end
            if (v && act_ready)
              sent = 1'b1;
          end
          if (!sent) begin
            n_checks++;
            n_errors++;
            $display("FAIL stream_timeout actual=not_accepted required=accepted");
          end
          beats++;
        end
      end
    end
    @(negedge clk);
    act_valid = 1'b0;
    start     = 1'b0;
    w_we      = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int guard;
    guard = 0;
    while (done_cnt == d0 && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("done_pulse_count", 64'(done_cnt - d0), 64'd1);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_after_run", 64'(busy), 64'd0);
    chk("act_ready_after_run", 64'(act_ready), 64'd0);
    chk("pending_results", 64'(wp - rp), 64'd0);
  endtask

  task automatic run(input int mode, input bit illegal);
    int d0;
    d0 = done_cnt;
    start_run();
    stream(mode, illegal, OUT_NUM * N);
    wait_done(d0);
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #3;
    rst       = 1'b0;
    act_valid = 1'b0;
    start     = 1'b0;
    w_we      = 1'b0;
    for (int i = 0; i < N*N; i++)
      wm[i] = 0;
    #1;
    chk("rst_act_ready", 64'(act_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_idx", 64'(res_idx), 64'd0);
    chk("rst_res_flat", 64'(res_flat), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < N*N; i++)
      wm[i] = 0;
    repeat (3) @(negedge clk);
    chk("init_res_flat", 64'(res_flat), 64'd0);
    chk("init_res_valid", 64'(res_valid), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_act_ready", 64'(act_ready), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);

    set_w(0, 1);
    set_x(0, 2);
    run(0, 1'b0);
    chk("uniform_flat", 64'(res_flat), 64'({4{8'd18}}));

    set_w(1, 0);
    set_x(1, 0);
    run(0, 1'b0);
    chk("indexed_flat", 64'(res_flat), 64'({8'd180, 8'd135, 8'd90, 8'd45}));

    set_w(0, 16);
    set_x(0, 16);
    run(0, 1'b0);
    chk("wrap_16x16", 64'(res_flat), 64'd0);

    set_w(3, 0);
    set_x(0, 255);
    run(0, 1'b0);
    chk("wrap_255sq", 64'(res_flat), 64'({4{8'd1}}));

    write_w(9, 77);
    set_x(0, 1);
    run(0, 1'b0);
    chk("addr9_ignored", 64'(res_flat), 64'({4{8'd255}}));

    set_w(1, 0);
    set_x(1, 0);
    run(1, 1'b1);
    chk("bubble_illegal_flat", 64'(res_flat), 64'({8'd180, 8'd135, 8'd90, 8'd45}));
    set_x(0, 1);
    run(0, 1'b0);
    chk("weights_kept", 64'(res_flat), 64'({4{8'd45}}));

    repeat (4) begin
      set_w(2, 0);
      set_x(2, 0);
      run(2, 1'b1);
    end

    set_w(2, 0);
    set_x(2, 0);
    d0 = done_cnt;
    start_run();
    stream(0, 1'b0, 5);
    reset_mid();
    repeat (10) @(negedge clk);
    chk("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
    chk("idle_after_abort", 64'(busy), 64'd0);

    set_x(2, 0);
    run(0, 1'b0);
    chk("zero_weights_flat", 64'(res_flat), 64'd0);

    set_w(2, 0);
    set_x(2, 0);
    run(2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_dot_engine.md
Name: systolic_dot_engine

Overview:
- Parametrised, self-sequencing successor to the fixed 3x3 weight-stationary array.
- Holds an N x N stationary weight kernel and accepts OUT_NUM activation windows as N-beat column streams.
- Computes one modular dot product per window and writes each result to an indexed result register.
- An internal FSM replaces the external enable/demux-select sequencing, with a start/busy/done handshake and valid/ready activation input.

Parameters:
- DATA_W, 8: width of weights and activation elements (unsigned).
- N, 3: kernel and window dimension (rows = columns = N), N >= 2.
- OUT_NUM, 4: windows per run, which is also the number of result registers.
- ACC_W, 8: result width; all arithmetic is modulo 2^ACC_W.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous and active-low.
- start  in  1  run request; sampled only in IDLE.
- w_we  in  1  weight write strobe; honoured only in IDLE.
- w_addr  in  clog2(N*N)  weight index, r*N+c.
- w_data  in  DATA_W  weight value.
- act_valid  in  1  activation beat valid.
- act_ready  out  1  engine accepts a beat this cycle.
- act_in  in  N*DATA_W  beat t of a window; slice r = X[r][t].
- res_flat  out  OUT_NUM*ACC_W  result registers; slice k = result of window k.
- res_valid  out  1  one-cycle pulse when a result register is updated.
- res_idx  out  clog2(OUT_NUM)  index of the register just updated.
- busy  out  1  high in STREAM and DRAIN.
- done  out  1  one-cycle pulse at the end of a run.

Behaviour:
- Reset (rst=0, asynchronous), all of the following go to 0 immediately, with no wait for a clock edge:
  - weights
  - result registers
  - counters and the pipeline valid/index shift line
  - act_ready, res_valid, res_idx, busy, done
- Reset also forces the FSM to IDLE. A reset in mid-run abandons the run; no result or done is produced for it.

- FSM states:
  - IDLE:
    - w_we=1 with w_addr < N*N writes W[addr] on the edge; w_addr >= N*N is ignored.
    - start=1 moves to STREAM and clears the beat counter (0..N-1) and the window counter (0..OUT_NUM-1).
  - STREAM:
    - act_ready=1 and busy=1.
    - A beat is accepted on an edge where act_valid=1 and act_ready=1.
    - Idle cycles between beats or between windows are legal.
    - On beat N-1 the beat counter wraps to 0 and the window counter increments.
    - Acceptance of the last beat of window OUT_NUM-1 moves to DRAIN; act_ready=0 from the next cycle.
  - DRAIN:
    - busy=1 and act_ready=0.
    - Stays here until the final result is written, then moves to DONE.
  - DONE:
    - done=1 for exactly one cycle, busy=0.
    - Next state is IDLE.
- start in any state other than IDLE is ignored. w_we outside IDLE is ignored, so weights are stable throughout a run.

- Arithmetic:
  - result_k = sum over r,c of X_k[r][c] * W[r][c].
  - Each product and each partial sum is truncated to ACC_W bits, unsigned; carry out is discarded.
  - Per-beat column products, an adder tree and a per-window accumulator are the expected structure, with a pipelined output.
- Latency:
  - Let E be the edge that accepts the last beat of window k. On edge E+N+1, res_flat slice k takes result_k.
  - In the cycle following that edge, res_valid=1 and res_idx=k.
  - Latency is fixed, independent of bubbles. Windows may overlap in flight; each keeps its own index.
- Result registers hold their value until overwritten by a later run or cleared by reset. start does not clear them.
- DONE is entered on the edge after the final result update, so done rises one cycle after the last res_valid.

Test Plan:
- Reset/idle (N=3, DATA_W=8, ACC_W=8, OUT_NUM=4): assert rst=0 mid-clock -> all outputs 0 at once. Release with no stimulus -> act_ready=0, busy=0, done=0.
- Uniform: load W all 1, start, stream 4 windows of X all 2 back-to-back -> four res_valid pulses, res_idx 0,1,2,3, each slice = 18. done pulses one cycle after the last res_valid; busy then falls to 0.
- Indexed values: W[r][c] = 3r+c+1 (1..9), window k has all elements k+1 -> slices 45, 90, 135, 180. Each update lands exactly 4 edges after that window's final beat.
- Wrap/truncation: W all 16, X all 16 -> 0. W[4]=255 with all other weights 0, X all 255 -> 1. w_addr=9 write is ignored, and the previous W values hold.
- Bubbles and illegal controls: act_valid toggled every other cycle gives the same results as the Indexed values scenario, with latency still 4 edges from each last beat. start and w_we=1 pulsed during STREAM -> no effect on results or weights.
- Mid-run reset: rst=0 after 5 accepted beats -> FSM returns to IDLE, weights and results read 0, no done pulse. A new run without reloading weights -> all four slices 0.
